// File: rtl/ysyx_22050133_ifu_pkg.sv
// Shared types and constants for the ysyx_22050133 instruction-fetch unit.
// The optional perf counters are enabled with YSYX_22050133_IFU_PERF_EN.
package ysyx_22050133_ifu_pkg;

    localparam int XLEN    = 64;
    localparam int INST_W  = 32;
    localparam int ENTRY_W = XLEN + INST_W;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h8000_0000;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } ifu_state_e;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ysyx_22050133_ifu_fifo.sv
// Small synchronous FIFO holding fetched {pc, inst} entries for decode.
// Flush empties it in one cycle and takes priority over push/pop.
module ysyx_22050133_ifu_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 96
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == (AW+1)'(DEPTH));
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];
    assign do_pop    = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ysyx_22050133_ifu.sv
// RV64 fetch stage: PC, one-outstanding fetch FSM, redirect squash, buffered output to decode.
// Define YSYX_22050133_IFU_PERF_EN to add the perf_fetch_cnt / perf_stall_cnt outputs.
module ysyx_22050133_ifu
    import ysyx_22050133_ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
`ifdef YSYX_22050133_IFU_PERF_EN
    output logic [63:0] perf_fetch_cnt,
    output logic [63:0] perf_stall_cnt,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [63:0] out_pc
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    ifu_state_e       state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  req_pc_q, req_pc_d;
    logic             inflight_q, inflight_d;
    logic             drop_q, drop_d;

    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   credit_used;
    logic             fifo_full, fifo_empty;
    logic             fifo_push, fifo_pop;
    logic             req_fire, resp_fire;
    fetch_entry_t     push_entry, head_entry;

    // Queued plus in-flight entries must fit, so a response always has a slot.
    assign credit_used    = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    assign imem_req_valid = !rst && (state_q == S_REQ) && !redirect_valid
                            && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding (e.g. left over from before reset) is ignored.
    assign resp_fire      = (state_q == S_WAIT) && inflight_q && imem_resp_valid;

    assign out_valid  = !fifo_empty;
    assign out_pc     = out_valid ? head_entry.pc   : '0;
    assign out_inst   = out_valid ? head_entry.inst : '0;
    assign fifo_pop   = out_valid && out_ready;
    assign push_entry = '{pc: req_pc_q, inst: imem_resp_data};
    assign fifo_push  = resp_fire && !drop_q && !redirect_valid && (!fifo_full || fifo_pop);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        case (state_q)
            S_REQ: begin
                if (req_fire) begin
                    req_pc_d   = pc_q;
                    pc_d       = pc_q + 64'd4;
                    inflight_d = 1'b1;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (resp_fire) begin
                    inflight_d = 1'b0;
                    drop_d     = 1'b0;
                    state_d    = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
        // Redirect overrides the PC; an outstanding fetch is marked to be thrown away.
        if (redirect_valid) begin
            pc_d = align_pc(redirect_pc);
            if ((state_q == S_WAIT) && !resp_fire) begin
                drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= align_pc(RESET_PC);
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    ysyx_22050133_ifu_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .head_data (head_entry),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef YSYX_22050133_IFU_PERF_EN
    logic [63:0] perf_fetch_cnt_q, perf_fetch_cnt_d;
    logic [63:0] perf_stall_cnt_q, perf_stall_cnt_d;

    always_comb begin
        perf_fetch_cnt_d = perf_fetch_cnt_q + {63'd0, fifo_push};
        perf_stall_cnt_d = perf_stall_cnt_q + {63'd0, (out_ready && !out_valid)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt_q <= '0;
            perf_stall_cnt_q <= '0;
        end else begin
            perf_fetch_cnt_q <= perf_fetch_cnt_d;
            perf_stall_cnt_q <= perf_stall_cnt_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_cnt_q;
    assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_22050133_ifu.sv
// Self-checking bench for ysyx_22050133_ifu: memory model with variable latency,
// expected {pc, inst} queue filled on request accept and checked on decode handshake.
module tb_ysyx_22050133_ifu;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [63:0] out_pc;
`ifdef YSYX_22050133_IFU_PERF_EN
    logic [63:0] perf_fetch_cnt;
    logic [63:0] perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    ysyx_22050133_ifu dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
`ifdef YSYX_22050133_IFU_PERF_EN
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_stall_cnt  (perf_stall_cnt),
`endif
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_inst        (out_inst),
        .out_pc          (out_pc)
    );

    int          errors = 0;
    int          checks = 0;
    logic [95:0] exp_q[$];
    logic [63:0] out_pc_log[$];
    int          out_cyc_log[$];

    logic        mem_pend = 1'b0;
    logic        mem_live = 1'b0;
    int          mem_cnt = 0;
    int          mem_lat = 1;
    logic [63:0] mem_addr = '0;
    logic        mem_ready_cfg = 1'b1;
    logic        out_ready_cfg = 1'b1;
    logic [63:0] model_pc = RESET_PC;
    int          redir_mode = 0;
    logic [63:0] redir_target = '0;
    logic        redir_seen = 1'b0;
    logic        last_out_valid = 1'b0;
    int          cyc = 0;
    int          req_cnt = 0;
    int          out_cnt = 0;
    logic [63:0] exp_fetch = '0;
    logic [63:0] exp_stall = '0;

    task automatic check_eq(input string tag, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [63:0] addr);
        return addr[31:0] ^ 32'hC0DE_1234;
    endfunction

    // One clock: drive inputs at negedge, account for the handshakes the next posedge completes.
    task automatic cycle();
        logic redir_now;
        logic out_fire;
        logic req_fire;
        logic [95:0] exp_entry;
        @(negedge clk);
        cyc++;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt <= 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = inst_of(mem_addr);
            end
        end
        imem_req_ready = mem_ready_cfg && !mem_pend;
        redir_now = 1'b0;
        if (!rst) begin
            case (redir_mode)
                1:       redir_now = imem_resp_valid;
                2:       redir_now = mem_pend && !imem_resp_valid;
                3:       redir_now = 1'b1;
                default: redir_now = 1'b0;
            endcase
        end
        redirect_valid = redir_now;
        redirect_pc    = redir_now ? redir_target : {$urandom, $urandom};
        if (redir_now) begin
            redir_mode = 0;
            redir_seen = 1'b1;
        end
        out_ready = out_ready_cfg;
        #1;
        last_out_valid = out_valid;
        if (rst) begin
            check_eq("rst_out_valid", out_valid, 0);
            check_eq("rst_req_valid", imem_req_valid, 0);
            check_eq("rst_out_pc", out_pc, 0);
            check_eq("rst_out_inst", out_inst, 0);
            if (imem_resp_valid) mem_pend = 1'b0;
        end else begin
            out_fire = out_valid && out_ready;
            req_fire = imem_req_valid && imem_req_ready;
            if (out_ready && !out_valid) exp_stall++;
            if (out_fire) begin
                if (exp_q.size() == 0) begin
                    check_eq("out_unexpected_pc", out_pc, 0);
                end else begin
                    exp_entry = exp_q.pop_front();
                    check_eq("out_entry", {out_pc, out_inst}, exp_entry);
                end
                out_pc_log.push_back(out_pc);
                out_cyc_log.push_back(cyc);
                out_cnt++;
            end
            if (imem_resp_valid) begin
                if (mem_live && !redir_now) exp_fetch++;
                mem_pend = 1'b0;
                mem_live = 1'b0;
            end
            if (redir_now) begin
                check_eq("req_in_redirect", imem_req_valid, 0);
                exp_q.delete();
                model_pc = {redir_target[63:2], 2'b00};
                mem_live = 1'b0;
            end
            if (req_fire) begin
                check_eq("req_addr", imem_req_addr, model_pc);
                exp_q.push_back({model_pc, inst_of(model_pc)});
                model_pc = model_pc + 64'd4;
                mem_pend = 1'b1;
                mem_live = 1'b1;
                mem_cnt  = mem_lat;
                mem_addr = imem_req_addr;
                req_cnt++;
            end
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        out_pc_log.delete();
        out_cyc_log.delete();
        model_pc  = RESET_PC;
        mem_live  = 1'b0;
        exp_fetch = '0;
        exp_stall = '0;
        req_cnt   = 0;
        out_cnt   = 0;
        redir_mode = 0;
        repeat (n) cycle();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_until_pend(input string tag);
        int n = 0;
        while (!(mem_pend && mem_live) && n < 50) begin
            cycle();
            n++;
        end
        check_eq({tag, "_inflight_reached"}, mem_pend && mem_live, 1);
    endtask

    task automatic wait_outs(input string tag, input int k);
        int n = 0;
        while (out_pc_log.size() < k && n < 100) begin
            cycle();
            n++;
        end
        check_eq({tag, "_outs_reached"}, out_pc_log.size() >= k, 1);
    endtask

    task automatic quiesce(input string tag);
        int n = 0;
        mem_ready_cfg = 1'b0;
        out_ready_cfg = 1'b1;
        redir_mode    = 0;
        while ((mem_pend || exp_q.size() != 0) && n < 100) begin
            cycle();
            n++;
        end
        check_eq({tag, "_drained"}, mem_pend || (exp_q.size() != 0), 0);
        mem_ready_cfg = 1'b1;
    endtask

    task automatic perf_check(input string tag);
`ifdef YSYX_22050133_IFU_PERF_EN
        @(posedge clk);
        #1;
        check_eq({tag, "_perf_fetch"}, perf_fetch_cnt, exp_fetch);
        check_eq({tag, "_perf_stall"}, perf_stall_cnt, exp_stall);
`endif
    endtask

    initial begin
        int rel_cyc;
        // Scenario 1: streaming after reset, one instruction every two cycles.
        mem_lat = 1;
        do_reset(3);
        rel_cyc = cyc;
        repeat (20) cycle();
        check_eq("s1_count", out_cyc_log.size() >= 6, 1);
        check_eq("s1_first_cycle", out_cyc_log[0] - rel_cyc, 3);
        check_eq("s1_first_pc", out_pc_log[0], 64'h8000_0000);
        check_eq("s1_second_pc", out_pc_log[1], 64'h8000_0004);
        check_eq("s1_third_pc", out_pc_log[2], 64'h8000_0008);
        for (int i = 1; i < 5; i++) begin
            check_eq("s1_gap", out_cyc_log[i] - out_cyc_log[i-1], 2);
        end

        // Scenario 2: decode stalled, credit limits outstanding fetches to the FIFO depth.
        quiesce("s2_pre");
        do_reset(2);
        out_ready_cfg = 1'b0;
        repeat (20) cycle();
        check_eq("s2_req_count", req_cnt, 2);
        check_eq("s2_req_valid_low", imem_req_valid, 0);
        check_eq("s2_out_valid", out_valid, 1);
        out_ready_cfg = 1'b1;
        wait_outs("s2", 2);
        check_eq("s2_drain0", out_pc_log[0], 64'h8000_0000);
        check_eq("s2_drain1", out_pc_log[1], 64'h8000_0004);
        repeat (10) cycle();
        check_eq("s2_resume", req_cnt > 2, 1);
        quiesce("s2_post");
`ifdef YSYX_22050133_IFU_PERF_EN
        check_eq("s2_fetch_vs_delivered", exp_fetch, out_cnt);
`endif
        perf_check("s2");

        // Scenario 3: redirect with a slow fetch in flight; the late response is discarded.
        mem_lat = 5;
        run_until_pend("s3");
        redir_target = 64'h8000_1003;
        redir_mode   = 2;
        redir_seen   = 1'b0;
        cycle();
        check_eq("s3_redirected", redir_seen, 1);
        out_pc_log.delete();
        mem_lat = 1;
        wait_outs("s3", 1);
        check_eq("s3_first_pc", out_pc_log[0], 64'h8000_1000);

        // Scenario 4: redirect coinciding with a response while the buffer is full of credit.
        out_ready_cfg = 1'b0;
        begin
            int n = 0;
            while (!(last_out_valid && mem_pend && mem_live) && n < 50) begin
                cycle();
                n++;
            end
            check_eq("s4_setup", last_out_valid && mem_pend && mem_live, 1);
        end
        redir_target = 64'h0000_0000_9000_0040;
        redir_mode   = 1;
        redir_seen   = 1'b0;
        cycle();
        check_eq("s4_redirected", redir_seen, 1);
        cycle();
        check_eq("s4_fifo_empty", last_out_valid, 0);
        out_pc_log.delete();
        out_ready_cfg = 1'b1;
        wait_outs("s4", 1);
        check_eq("s4_first_pc", out_pc_log[0], 64'h0000_0000_9000_0040);

        // Scenario 5: reset while waiting on memory, stale response arrives after release.
        mem_lat = 6;
        run_until_pend("s5");
        do_reset(2);
        mem_lat = 1;
        wait_outs("s5", 1);
        check_eq("s5_first_pc", out_pc_log[0], RESET_PC);

        // PC wrap at the top of the address space.
        redir_target = 64'hFFFF_FFFF_FFFF_FFFE;
        redir_mode   = 3;
        redir_seen   = 1'b0;
        cycle();
        check_eq("wrap_redirected", redir_seen, 1);
        out_pc_log.delete();
        wait_outs("wrap", 2);
        check_eq("wrap_pc0", out_pc_log[0], 64'hFFFF_FFFF_FFFF_FFFC);
        check_eq("wrap_pc1", out_pc_log[1], 64'h0);

        // Random traffic: backpressure, latency and redirects of every flavour.
        for (int i = 0; i < 400; i++) begin
            out_ready_cfg = 1'($urandom_range(0, 1));
            mem_ready_cfg = ($urandom_range(0, 3) != 0);
            mem_lat       = $urandom_range(1, 4);
            if (redir_mode == 0 && $urandom_range(0, 15) == 0) begin
                redir_mode   = $urandom_range(1, 3);
                redir_target = {$urandom, $urandom};
            end
            cycle();
        end
        quiesce("final");
        perf_check("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        check_eq("watchdog_timeout", 1, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
